// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches {opcode, operand} words from a combinational ROM,
// issues playfield commands over valid/ready and handles WAIT/JUMP/HALT flow locally.
module instruction_sequencer #(
    parameter int WIDTH               = 8,
    parameter int INSTRACTION_NUMBERS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               restart,
    output logic [WIDTH-1:0]   curr_command,
    input  logic [2*WIDTH-1:0] instr_data,
    output logic               cmd_valid,
    output logic [WIDTH-1:0]   cmd_op,
    output logic [WIDTH-1:0]   cmd_arg,
    input  logic               cmd_ready,
    output logic               halted,
    output logic               err
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [WIDTH-1:0] OP_DROP = WIDTH'(4);
    localparam logic [WIDTH-1:0] OP_WAIT = WIDTH'(5);
    localparam logic [WIDTH-1:0] OP_JUMP = WIDTH'(6);
    localparam logic [WIDTH-1:0] OP_HALT = WIDTH'(7);
    localparam logic [WIDTH-1:0] DEPTH   = WIDTH'(INSTRACTION_NUMBERS);
    localparam logic [WIDTH-1:0] LAST_PC = WIDTH'(INSTRACTION_NUMBERS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] fetch_op;
    logic [WIDTH-1:0] fetch_arg;
    logic [WIDTH-1:0] pc_inc;

    assign fetch_op  = instr_data[2*WIDTH-1:WIDTH];
    assign fetch_arg = instr_data[WIDTH-1:0];
    // ROM depth need not be a power of two, so the wrap is explicit.
    assign pc_inc    = (pc_q == LAST_PC) ? '0 : pc_q + WIDTH'(1);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            S_FETCH: begin
                op_d  = fetch_op;
                arg_d = fetch_arg;
                if (fetch_op <= OP_DROP) begin
                    state_d = S_ISSUE;
                end else if (fetch_op == OP_WAIT) begin
                    if (fetch_arg == '0) begin
                        pc_d = pc_inc;
                    end else begin
                        cnt_d   = fetch_arg;
                        state_d = S_WAIT;
                    end
                end else if (fetch_op == OP_JUMP) begin
                    pc_d = fetch_arg % DEPTH;
                end else if (fetch_op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                // The arg=0 bypass guarantees cnt_q >= 1 here, so no underflow.
                if (tick) begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (restart) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            op_q    <= '0;
            arg_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign curr_command = pc_q;
    assign cmd_valid    = (state_q == S_ISSUE);
    assign cmd_op       = op_q;
    assign cmd_arg      = arg_q;
    assign halted       = (state_q == S_HALT);
    assign err          = err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized programs against an instruction-level model.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        restart = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [7:0]  curr_command;
    logic [15:0] instr_data;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        halted;
    logic        err;

    logic [15:0] rom [4];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign instr_data = rom[curr_command[1:0]];

    instruction_sequencer #(.WIDTH(8), .INSTRACTION_NUMBERS(4)) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .restart(restart),
        .curr_command(curr_command),
        .instr_data(instr_data),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_arg(cmd_arg),
        .cmd_ready(cmd_ready),
        .halted(halted),
        .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // After return, the current cycle is the first FETCH following reset.
    task automatic do_reset();
        rst = 1'b0; tick = 1'b0; restart = 1'b0; cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", curr_command, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_op", cmd_op, 0);
        check("rst_arg", cmd_arg, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
    endtask

    task automatic expect_st(input string name, input int pc, input bit v, input bit h, input bit e);
        check({name, "_pc"}, curr_command, pc);
        check({name, "_valid"}, cmd_valid, v);
        check({name, "_halted"}, halted, h);
        check({name, "_err"}, err, e);
    endtask

    function automatic logic [15:0] ins(input int op, input int arg);
        ins = {op[7:0], arg[7:0]};
    endfunction

    typedef struct {
        bit         tick;
        bit         ready;
        bit         restart;
        bit         exp_valid;
        logic [7:0] exp_op;
        logic [7:0] exp_arg;
        logic [7:0] exp_pc;
        bit         exp_halted;
        bit         exp_err;
    } vec_t;

    // Instruction-level model: the ordered list of commands the program transfers.
    logic [15:0] exp_q [$];

    function automatic void build_model();
        int pc;
        int op;
        int arg;
        exp_q.delete();
        pc = 0;
        for (int s = 0; s < 3000; s++) begin
            op  = int'(rom[pc][15:8]);
            arg = int'(rom[pc][7:0]);
            if (op <= 4) begin
                exp_q.push_back(rom[pc]);
                pc = (pc + 1) % 4;
            end else if (op == 6) begin
                pc = arg % 4;
            end else if (op == 7) begin
                break;
            end else begin
                pc = (pc + 1) % 4;
            end
        end
    endfunction

    initial begin
        vec_t vecs [8];
        int   vcnt;
        int   xfers;

        // Directed table: {SPAWN 2, LEFT 5, JUMP 0, HALT} with ready held high.
        vecs[0] = '{0, 1, 0, 0, 8'h00, 8'h00, 8'd0, 0, 0};
        vecs[1] = '{0, 1, 0, 1, 8'h00, 8'h02, 8'd0, 0, 0};
        vecs[2] = '{1, 1, 0, 0, 8'h00, 8'h00, 8'd1, 0, 0};
        vecs[3] = '{0, 1, 1, 1, 8'h01, 8'h05, 8'd1, 0, 0};
        vecs[4] = '{0, 1, 0, 0, 8'h00, 8'h00, 8'd2, 0, 0};
        vecs[5] = '{1, 1, 0, 0, 8'h00, 8'h00, 8'd0, 0, 0};
        vecs[6] = '{0, 1, 0, 1, 8'h00, 8'h02, 8'd0, 0, 0};
        vecs[7] = '{0, 1, 0, 0, 8'h00, 8'h00, 8'd1, 0, 0};

        rom[0] = ins(0, 2); rom[1] = ins(1, 5); rom[2] = ins(6, 0); rom[3] = ins(7, 0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick = vecs[i].tick; cmd_ready = vecs[i].ready; restart = vecs[i].restart;
            check($sformatf("tbl%0d_valid", i), cmd_valid, vecs[i].exp_valid);
            check($sformatf("tbl%0d_pc", i), curr_command, vecs[i].exp_pc);
            check($sformatf("tbl%0d_halted", i), halted, vecs[i].exp_halted);
            check($sformatf("tbl%0d_err", i), err, vecs[i].exp_err);
            if (vecs[i].exp_valid) begin
                check($sformatf("tbl%0d_op", i), cmd_op, vecs[i].exp_op);
                check($sformatf("tbl%0d_arg", i), cmd_arg, vecs[i].exp_arg);
            end
            step();
        end
        tick = 0; restart = 0;

        // Back-pressure: ready low for 5 valid cycles, raised on the 6th.
        rom[0] = ins(0, 1); rom[1] = ins(7, 0); rom[2] = ins(7, 0); rom[3] = ins(7, 0);
        do_reset();
        vcnt = 0; xfers = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_valid) begin
                vcnt++;
                cmd_ready = (vcnt == 6);
                check("stall_op", cmd_op, 0);
                check("stall_arg", cmd_arg, 1);
                if (cmd_ready) xfers++;
            end else begin
                cmd_ready = 1'b0;
            end
            step();
        end
        check("stall_valid_cycles", vcnt, 6);
        check("stall_transfers", xfers, 1);
        check("stall_then_halt", halted, 1);
        check("stall_halt_pc", curr_command, 1);

        // WAIT 3 with an uncounted entry tick and irregular in-WAIT ticks.
        rom[0] = ins(5, 3); rom[1] = ins(0, 0); rom[2] = ins(7, 0); rom[3] = ins(7, 0);
        do_reset();
        tick = 1'b1;
        expect_st("wait_entry", 0, 0, 0, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            tick = (i == 1 || i == 4 || i == 5);
            expect_st($sformatf("wait_c%0d", i + 2), 0, 0, 0, 0);
            step();
        end
        tick = 1'b0;
        expect_st("wait_refetch", 1, 0, 0, 0);
        step();
        expect_st("wait_issue", 1, 1, 0, 0);

        // WAIT 0 falls straight through.
        rom[0] = ins(5, 0);
        do_reset();
        step();
        expect_st("wait0_next", 1, 0, 0, 0);
        step();
        expect_st("wait0_issue", 1, 1, 0, 0);

        // Illegal opcode at address 1.
        rom[0] = ins(1, 0); rom[1] = ins(9, 0); rom[2] = ins(2, 0); rom[3] = ins(7, 0);
        do_reset();
        cmd_ready = 1'b1;
        expect_st("ill_c1", 0, 0, 0, 0); step();
        expect_st("ill_c2", 0, 1, 0, 0); step();
        expect_st("ill_c3", 1, 0, 0, 0); step();
        expect_st("ill_c4", 2, 0, 0, 1); step();
        expect_st("ill_c5", 2, 1, 0, 1);
        check("ill_c5_op", cmd_op, 2);
        step();
        expect_st("ill_c6", 3, 0, 0, 1); step();
        expect_st("ill_c7", 3, 0, 1, 1);

        // HALT at address 3; restart is ignored while fetching.
        rom[0] = ins(6, 3); rom[1] = ins(1, 0); rom[2] = ins(1, 0); rom[3] = ins(7, 0);
        do_reset();
        restart = 1'b1;
        expect_st("halt_c1", 0, 0, 0, 0); step();
        restart = 1'b0;
        expect_st("halt_c2", 3, 0, 0, 0); step();
        tick = 1'b1; cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_st($sformatf("halt_hold%0d", i), 3, 0, 1, 0);
            step();
        end
        tick = 1'b0; cmd_ready = 1'b0; restart = 1'b1;
        step();
        restart = 1'b0;
        expect_st("halt_restart", 0, 0, 0, 0);
        step(); step();
        expect_st("halt_again", 3, 0, 1, 0);
        rst = 1'b0; restart = 1'b1;
        step();
        rst = 1'b1; restart = 1'b0;
        expect_st("rst_restart_both", 0, 0, 0, 0);

        // Reset in ISSUE with a stalled handshake, err already set.
        rom[0] = ins(9, 0); rom[1] = ins(0, 1); rom[2] = ins(7, 0); rom[3] = ins(7, 0);
        do_reset();
        step(); step();
        expect_st("pre_rst_issue", 1, 1, 0, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        expect_st("rst_in_issue", 0, 0, 0, 0);
        check("rst_in_issue_op", cmd_op, 0);
        check("rst_in_issue_arg", cmd_arg, 0);
        step();
        expect_st("rst_in_issue_refetch", 1, 0, 0, 1);

        // JUMP 6 in a depth-4 ROM lands on address 2.
        rom[0] = ins(6, 6); rom[1] = ins(7, 0); rom[2] = ins(3, 7); rom[3] = ins(7, 0);
        do_reset();
        step();
        expect_st("jump_mod", 2, 0, 0, 0);
        step();
        check("jump_mod_op", cmd_op, 3);
        check("jump_mod_arg", cmd_arg, 7);

        // Randomized programs checked against the instruction-level model.
        for (int p = 0; p < 6; p++) begin
            int          got;
            bit          prev_stall;
            logic [15:0] prev_cmd;
            for (int a = 0; a < 4; a++) begin
                int op;
                int arg;
                op = (p == 0 && a == 3) ? 6 : int'($urandom_range(0, 9));
                case (op)
                    0:       arg = int'($urandom_range(0, 2));
                    5:       arg = int'($urandom_range(0, 3));
                    7:       op  = (p < 3) ? 4 : 7;
                    default: arg = int'($urandom_range(0, 255));
                endcase
                if (op == 4 || op == 7) arg = int'($urandom_range(0, 255));
                rom[a] = ins(op, arg);
            end
            build_model();
            do_reset();
            got = 0;
            prev_stall = 1'b0;
            prev_cmd = '0;
            for (int c = 0; c < 1500; c++) begin
                tick      = $urandom_range(0, 1);
                cmd_ready = $urandom_range(0, 1);
                if (curr_command > 8'd3) begin
                    check("rand_pc_range", curr_command, 0);
                end
                if (prev_stall) begin
                    check("rand_stall_valid", cmd_valid, 1);
                    check("rand_stall_cmd", {cmd_op, cmd_arg}, prev_cmd);
                end
                if (cmd_valid && cmd_ready) begin
                    if (got < exp_q.size()) begin
                        check($sformatf("rand_p%0d_xfer%0d", p, got), {cmd_op, cmd_arg}, exp_q[got]);
                    end else begin
                        check("rand_extra_xfer", got, exp_q.size());
                    end
                    got++;
                end
                prev_stall = cmd_valid && !cmd_ready;
                prev_cmd   = {cmd_op, cmd_arg};
                step();
            end
            if (exp_q.size() > 0 && exp_q.size() < 50) begin
                check($sformatf("rand_p%0d_count", p), got, exp_q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
